// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, round-robin arbiter in front of a single-port
// 32-bit data memory. One access at a time, fixed three-cycle latency
// (IDLE -> ACCESS -> RESP).
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata valid and
// holds them until it sees x_ack (a one-cycle pulse; err and rdata are valid
// in that same cycle). A request is accepted only when it is sampled in IDLE.
// Outside IDLE the requester inputs are ignored. A req still high in the IDLE
// cycle after its ack is a fresh request, and addr/we/wdata may change in that
// same cycle.
module mem_arbiter #(
    parameter int MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic        mem_writeEnable,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // First byte address past the end of the attached memory.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_latch;

    // Latched request; r_addr/r_wdata also drive the memory pins directly so
    // the pins hold their last values outside ACCESS.
    logic        r_win_b;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_last_b;
    logic [31:0] r_rdata;

    logic        w_any_req;
    logic        w_grant_b;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic        w_in_access;
    logic        w_in_resp;

    // Round-robin grant: a lone requester wins; on a tie the requester that
    // was not served last wins.
    always_comb begin
        w_any_req = a_req | b_req;
        w_grant_b = 1'b0;
        if (a_req && b_req) begin
            w_grant_b = ~r_last_b;
        end else begin
            w_grant_b = b_req;
        end
        w_sel_we    = w_grant_b ? b_we    : a_we;
        w_sel_addr  = w_grant_b ? b_addr  : a_addr;
        w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
        // Misaligned or out-of-range requests are rejected, never touching memory.
        w_sel_err   = (w_sel_addr[1:0] != 2'b00) || ({1'b0, w_sel_addr} >= ADDR_LIMIT);
    end

    // Next-state logic; a request is only accepted from IDLE.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ACCESS;
                    w_latch      = 1'b1;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts whatever access is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winning request and remember who was served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_b  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_last_b <= 1'b1;
        end else if (w_latch) begin
            r_win_b  <= w_grant_b;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_err    <= w_sel_err;
            r_last_b <= w_grant_b;
        end
    end

    // Read data is sampled at the end of ACCESS and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (r_state == ST_ACCESS) begin
            r_rdata <= (r_we || r_err) ? 32'd0 : mem_dataOut;
        end
    end

    // Output decode; the write strobe is also gated by reset so an access
    // aborted in ACCESS never reaches memory.
    always_comb begin
        w_in_access     = (r_state == ST_ACCESS);
        w_in_resp       = (r_state == ST_RESP);
        a_ack           = w_in_resp & ~r_win_b;
        b_ack           = w_in_resp &  r_win_b;
        err             = w_in_resp &  r_err;
        rdata           = r_rdata;
        busy            = (r_state != ST_IDLE);
        mem_address     = r_addr;
        mem_dataIn      = r_wdata;
        mem_writeEnable = w_in_access & r_we & ~r_err & ~reset;
        dbg_state       = r_state;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and hand-sequenced checks of mem_arbiter
// against a behavioural memory and a reference memory image.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack, err, busy, mem_writeEnable;
    logic [31:0] rdata, mem_address, mem_dataIn, mem_dataOut;
    logic [1:0]  dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .dbg_state(dbg_state)
    );

    // ---------------- attached memory ----------------
    logic [31:0] mem [MW];
    logic        mem_clear = 1'b1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'd0;
        end else if (mem_writeEnable && mem_address[31:10] == 22'd0) begin
            mem[mem_address[9:2]] <= mem_dataIn;
        end
    end
    assign mem_dataOut = (mem_address[31:10] == 22'd0) ? mem[mem_address[9:2]] : 32'hBAD0BAD0;

    // ---------------- scoreboard ----------------
    logic [31:0] ref_mem [MW];
    logic [33:0] exp_q[$];   // {is_b, err, rdata}
    int n_cmp = 0;
    int n_fail = 0;
    int n_wr_seen = 0;
    int n_wr_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every ack pops one expected response.
    always @(negedge clk) begin
        logic [33:0] e;
        if (mem_writeEnable) n_wr_seen++;
        if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'({a_ack, b_ack}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_who", 32'({a_ack, b_ack}), e[33] ? 32'd1 : 32'd2);
                check("ack_err", 32'(err), 32'(e[32]));
                check("ack_rdata", rdata, e[31:0]);
            end
        end else if (err) begin
            check("err_without_ack", 32'(err), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called one delta after a posedge with the DUT in IDLE; returns likewise.
    task automatic do_access(input logic is_b, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_err,
                             input logic [31:0] exp_rdata);
        int  cycles;
        bit  seen;
        exp_q.push_back({is_b, exp_err, exp_rdata});
        if (we && !exp_err) begin
            ref_mem[addr[9:2]] = wdata;
            n_wr_exp++;
        end
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (is_b ? b_ack : a_ack) seen = 1'b1;
        end
        check("ack_latency", 32'(cycles), 32'd3);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= 32'(4 * MW));
    endfunction

    typedef struct packed {
        logic        is_b;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    // ---------------- main sequence ----------------
    initial begin
        int          who[4];
        int          at[4];
        int          n_ack;
        int          cyc;
        int          bad;
        logic        r_b, r_we;
        logic [31:0] r_addr, r_wd, r_idx, r_low;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000000C, 32'h00000008, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'h00000008};
        vecs[2]  = '{1'b1, 1'b0, 32'h00000006, 32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h00000400, 32'h00000055, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h000003FC, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h000003FC, 32'hA5A50001, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h000003FC, 32'h0,        1'b0, 32'hA5A50001};
        vecs[7]  = '{1'b0, 1'b1, 32'h00000010, 32'h11111111, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h00000010, 32'h0,        1'b0, 32'h11111111};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000401, 32'h00000077, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'h00000008};

        for (int i = 0; i < MW; i++) ref_mem[i] = 32'd0;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        mem_clear = 1'b0;
        @(negedge clk);
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_writeEnable), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_din", mem_dataIn, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Table of single accesses.
        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_rdata);
            check("model_err", 32'(model_err(vecs[i].addr)), 32'(vecs[i].exp_err));
        end

        // Reset again after traffic; then both requesters held: A,B,A,B.
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000000C;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h00000010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst2_mem_addr", mem_address, 32'd0);
        check("rst2_rdata", rdata, 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 32'h00000008});
        exp_q.push_back({1'b1, 1'b0, 32'h11111111});
        exp_q.push_back({1'b0, 1'b0, 32'h00000008});
        exp_q.push_back({1'b1, 1'b0, 32'h11111111});
        reset = 1'b0;
        n_ack = 0;
        cyc = 0;
        while (n_ack < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (a_ack || b_ack) begin
                who[n_ack] = b_ack ? 1 : 0;
                at[n_ack]  = cyc;
                n_ack++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("tie_ack_count", 32'(n_ack), 32'd4);
        if (n_ack == 4) begin
            for (int k = 0; k < 4; k++) check("tie_order", 32'(who[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++) check("tie_spacing", 32'(at[k] - at[k-1]), 32'd3);
        end
        @(posedge clk); #1;

        // Reset pulsed in ACCESS aborts a write of 0xDEADBEEF to 0x10.
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h00000010; a_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("abort_in_access", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        check("abort_we_gated", 32'(mem_writeEnable), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 32'h00000010, 32'h0, 1'b0, 32'h11111111);

        // B raises req during an A access: served only after IDLE.
        exp_q.push_back({1'b0, 1'b0, 32'h00000008});
        exp_q.push_back({1'b1, 1'b0, 32'h00000000});
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000000C;
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h00000020; b_wdata = 32'hCAFE0020;
        check("hold_busy_access", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("hold_a_ack", 32'({a_ack, b_ack}), 32'd2);
        check("hold_busy_resp", 32'(busy), 32'd1);
        a_req = 1'b0;
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("hold_b_access", 32'(dbg_state), 32'd1);
        check("hold_b_we", 32'(mem_writeEnable), 32'd1);
        check("hold_b_addr", mem_address, 32'h00000020);
        @(posedge clk); #1;
        check("hold_b_ack", 32'({a_ack, b_ack}), 32'd1);
        b_req = 1'b0;
        ref_mem[8] = 32'hCAFE0020;
        n_wr_exp++;
        @(posedge clk); #1;

        // Reset asserted in RESP: ack ends after that cycle.
        exp_q.push_back({1'b0, 1'b0, 32'h00000008});
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000000C;
        @(posedge clk); #1;
        a_req = 1'b0;
        @(posedge clk); #1;
        check("resp_ack", 32'(a_ack), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("resp_rst_ack", 32'({a_ack, b_ack}), 32'd0);
        check("resp_rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the reference image.
        for (int i = 0; i < 16; i++) begin
            r_b    = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_idx  = 32'($urandom_range(0, MW + 3));
            r_low  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            r_addr = (r_idx << 2) + r_low;
            r_wd   = $urandom;
            do_access(r_b, r_we, r_addr, r_wd, model_err(r_addr),
                      (!r_we && !model_err(r_addr)) ? ref_mem[r_addr[9:2]] : 32'd0);
        end

        // Final consistency.
        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'd0);
        check("write_count", 32'(n_wr_seen), 32'(n_wr_exp));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time guard.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
